// File: rtl/matrix_pkg.sv
// Shared sizing constants and scan FSM states for the LED matrix scanner.
package matrix_pkg;
  localparam int ROWS_DEF = 7;
  localparam int COLS_DEF = 5;
  localparam int ROW_W    = 3;

  typedef enum logic [1:0] {IDLE, SCAN, BLANK} state_t;
endpackage

// File: rtl/frame_buffer.sv
// Double-buffered frame store: writes land in the back bank, reads return the
// bank that will be in front after this edge, so a swapping edge shows the new frame.
module frame_buffer
  import matrix_pkg::*;
#(
  parameter int ROWS = ROWS_DEF,
  parameter int COLS = COLS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             swap,
  input  logic [ROW_W-1:0] rd_row,
  output logic [COLS-1:0]  rd_data
);

  logic [COLS-1:0] bank [2][ROWS];
  logic            front_sel;
  logic            rd_sel;
  logic            wr_ok;

  assign wr_ok = wr_en && (int'(wr_row) < ROWS);

  always_ff @(posedge clk) begin
    if (rst) begin
      front_sel <= 1'b0;
      for (int b = 0; b < 2; b++) begin
        for (int r = 0; r < ROWS; r++) begin
          bank[b][r] <= '0;
        end
      end
    end else begin
      if (wr_ok) bank[~front_sel][wr_row] <= wr_data;
      if (swap)  front_sel <= ~front_sel;
    end
  end

  // A write on the swapping edge belongs to the incoming frame, so bypass it.
  always_comb begin
    rd_sel  = swap ? ~front_sel : front_sel;
    rd_data = bank[rd_sel][rd_row];
    if (swap && wr_ok && (wr_row == rd_row)) rd_data = wr_data;
  end

endmodule

// File: rtl/matrix_scanner.sv
// Row-scan controller for a 7x5 LED matrix with inter-row blanking and
// frame swaps deferred to frame boundaries; writes stall while a swap is pending.
module matrix_scanner
  import matrix_pkg::*;
#(
  parameter int ROWS      = ROWS_DEF,
  parameter int COLS      = COLS_DEF,
  parameter int BLANK_CYC = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_tick,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [ROW_W-1:0] wr_row,
  input  logic [COLS-1:0]  wr_data,
  input  logic             commit,
  output logic [ROWS-1:0]  row_oh,
  output logic [COLS-1:0]  col,
  output logic [ROW_W-1:0] row_idx,
  output logic             frame_start
);

  localparam int CNT_W = (BLANK_CYC > 2) ? $clog2(BLANK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((BLANK_CYC > 0) ? BLANK_CYC - 1 : 0);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

  state_t           state, state_nxt;
  logic [ROW_W-1:0] row_nxt, row_inc;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             swap_pend, swap_pend_nxt;
  logic             swap, advance, fs_nxt, wr_en;
  logic [COLS-1:0]  rd_data;

  assign wr_en   = wr_valid && wr_ready;
  assign row_inc = (row_idx == LAST_ROW) ? '0 : row_idx + 1'b1;

  frame_buffer #(.ROWS(ROWS), .COLS(COLS)) u_fb (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_row  (wr_row),
    .wr_data (wr_data),
    .swap    (swap),
    .rd_row  (row_nxt),
    .rd_data (rd_data)
  );

  always_comb begin
    state_nxt = state;
    row_nxt   = row_idx;
    cnt_nxt   = cnt;
    advance   = 1'b0;
    swap      = 1'b0;
    fs_nxt    = 1'b0;
    case (state)
      IDLE: begin
        if (commit) begin
          swap      = 1'b1;
          state_nxt = SCAN;
          row_nxt   = '0;
          fs_nxt    = 1'b1;
        end
      end
      SCAN: begin
        if (scan_tick) begin
          if (BLANK_CYC == 0) begin
            advance = 1'b1;
          end else begin
            state_nxt = BLANK;
            cnt_nxt   = CNT_LOAD;
          end
        end
      end
      BLANK: begin
        if (cnt == '0) begin
          advance   = 1'b1;
          state_nxt = SCAN;
        end else begin
          cnt_nxt = cnt - 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Only a commit seen before the wrap edge may swap on it.
    if (advance) begin
      row_nxt = row_inc;
      if (row_inc == '0) begin
        fs_nxt = 1'b1;
        swap   = swap_pend;
      end
    end
    swap_pend_nxt = swap ? 1'b0 : (swap_pend | commit);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      row_idx     <= '0;
      cnt         <= '0;
      swap_pend   <= 1'b0;
      wr_ready    <= 1'b1;
      frame_start <= 1'b0;
      row_oh      <= '0;
      col         <= '0;
    end else begin
      state       <= state_nxt;
      row_idx     <= row_nxt;
      cnt         <= cnt_nxt;
      swap_pend   <= swap_pend_nxt;
      wr_ready    <= ~swap_pend_nxt;
      frame_start <= fs_nxt;
      if (state_nxt == SCAN) begin
        row_oh <= ROWS'(1) << row_nxt;
        col    <= rd_data;
      end else begin
        row_oh <= '0;
        col    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_matrix_scanner.sv
// Scoreboard bench: two scanners (2 and 0 blank cycles) on shared random and directed
// stimulus, each checked every cycle against a frame-level reference model.
module tb_matrix_scanner;

  typedef struct packed {
    logic [6:0] row_oh;
    logic [4:0] col;
    logic [2:0] row_idx;
    logic       fs;
    logic       wr_ready;
  } out_t;

  typedef struct packed {
    bit              active;
    logic [2:0]      row;
    logic [3:0]      blank_left;
    bit              fs;
    bit              pend;
    logic [6:0][4:0] front;
    logic [6:0][4:0] back;
  } mstate_t;

  logic       clk = 1'b0;
  logic       rst, scan_tick, wr_valid, commit;
  logic [2:0] wr_row;
  logic [4:0] wr_data;

  logic       rdy2, fs2, rdy0, fs0;
  logic [6:0] roh2, roh0;
  logic [4:0] col2, col0;
  logic [2:0] idx2, idx0;

  mstate_t m2, m0;
  out_t    q2[$], q0[$];
  out_t    a2, a0;
  int      n_cmp = 0, n_bad = 0, n_push = 0, n_pop = 0, cyc = 0;

  logic [4:0] pat [7] = '{5'b11000, 5'b00011, 5'b00010, 5'b00100, 5'b01101, 5'b00101, 5'b00100};

  always #5 clk = ~clk;

  matrix_scanner #(.ROWS(7), .COLS(5), .BLANK_CYC(2)) dut2 (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .wr_valid(wr_valid), .wr_ready(rdy2),
    .wr_row(wr_row), .wr_data(wr_data), .commit(commit), .row_oh(roh2), .col(col2),
    .row_idx(idx2), .frame_start(fs2));

  matrix_scanner #(.ROWS(7), .COLS(5), .BLANK_CYC(0)) dut0 (
    .clk(clk), .rst(rst), .scan_tick(scan_tick), .wr_valid(wr_valid), .wr_ready(rdy0),
    .wr_row(wr_row), .wr_data(wr_data), .commit(commit), .row_oh(roh0), .col(col0),
    .row_idx(idx0), .frame_start(fs0));

  // Reference: displayed/back frames as arrays, blanking as a countdown of dark cycles.
  function automatic mstate_t model(input mstate_t s, input int b);
    mstate_t         n;
    logic [6:0][4:0] tmp;
    bit              adv;
    n   = s;
    adv = 0;
    if (rst) begin
      n = '0;
      return n;
    end
    n.fs = 0;
    if (wr_valid && !s.pend && wr_row < 3'd7) n.back[wr_row] = wr_data;
    if (!s.active) begin
      if (commit) begin
        tmp = n.front; n.front = n.back; n.back = tmp;
        n.active = 1; n.row = 3'd0; n.fs = 1;
      end
    end else begin
      if (s.blank_left > 0) begin
        n.blank_left = s.blank_left - 4'd1;
        adv = (n.blank_left == 0);
      end else if (scan_tick) begin
        if (b == 0) adv = 1;
        else n.blank_left = 4'(b);
      end
      if (commit && !s.pend) n.pend = 1;
      if (adv) begin
        n.row = 3'((int'(s.row) + 1) % 7);
        if (n.row == 3'd0) begin
          n.fs = 1;
          if (s.pend) begin
            tmp = n.front; n.front = n.back; n.back = tmp;
            n.pend = 0;
          end
        end
      end
    end
    return n;
  endfunction

  function automatic out_t expect_of(input mstate_t s);
    out_t e;
    e = '0;
    e.row_idx  = s.row;
    e.fs       = s.fs;
    e.wr_ready = !s.pend;
    if (s.active && s.blank_left == 0) begin
      e.row_oh = 7'(1) << s.row;
      e.col    = s.front[s.row];
    end
    return e;
  endfunction

  task automatic check(input string nm, input out_t e, input out_t a);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got row_oh=%b col=%b idx=%0d fs=%b rdy=%b want row_oh=%b col=%b idx=%0d fs=%b rdy=%b",
               nm, cyc, a.row_oh, a.col, a.row_idx, a.fs, a.wr_ready,
               e.row_oh, e.col, e.row_idx, e.fs, e.wr_ready);
    end
  endtask

  always @(negedge clk) begin
    a2 = {roh2, col2, idx2, fs2, rdy2};
    a0 = {roh0, col0, idx0, fs0, rdy0};
    if (q2.size() > 0) begin check("blank2", q2.pop_front(), a2); n_pop++; end
    if (q0.size() > 0) begin check("blank0", q0.pop_front(), a0); n_pop++; end
  end

  task automatic step();
    m2 = model(m2, 2);
    m0 = model(m0, 0);
    q2.push_back(expect_of(m2));
    q0.push_back(expect_of(m0));
    n_push += 2;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic clr();
    rst = 0; scan_tick = 0; wr_valid = 0; commit = 0; wr_row = '0; wr_data = '0;
  endtask

  task automatic tick(input int gap);
    scan_tick = 1; step(); scan_tick = 0;
    repeat (gap) step();
  endtask

  task automatic write_row(input int r, input logic [4:0] d);
    wr_valid = 1; wr_row = 3'(r); wr_data = d; step(); wr_valid = 0;
  endtask

  task automatic do_commit();
    commit = 1; step(); commit = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "timeout");
  end

  initial begin
    m2 = '0;
    m0 = '0;
    clr();
    rst = 1;
    repeat (3) step();
    rst = 0;
    repeat (4) tick(9);
    for (int i = 0; i < 7; i++) write_row(i, pat[i]);
    do_commit();
    repeat (10) tick(5);
    for (int i = 0; i < 7; i++) write_row(i, ~pat[i]);
    do_commit();
    repeat (9) tick(5);
    write_row(7, 5'h1f);
    do_commit();
    scan_tick = 1;
    repeat (40) step();
    scan_tick = 0;
    repeat (5) step();
    rst = 1; step(); rst = 0;
    repeat (3) tick(9);
    repeat (3000) begin
      scan_tick = ($urandom_range(0, 2) == 0);
      wr_valid  = 1'($urandom_range(0, 1));
      wr_row    = 3'($urandom_range(0, 7));
      wr_data   = 5'($urandom);
      commit    = ($urandom_range(0, 29) == 0);
      rst       = ($urandom_range(0, 399) == 0);
      step();
    end
    clr();
    repeat (2) step();
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (n_pop != n_push) begin
      n_bad++;
      $display("FAIL drain got %0d popped want %0d", n_pop, n_push);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
